// File: rtl/core_pkg.sv
// Shared encodings for the core's address path: PC-select codes, access sizes and the address-unit FSM states.
package core_pkg;

  localparam logic [1:0] PC_REPLAY = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'b00,
    MA_FETCH = 2'b01,
    MA_DATA  = 2'b10
  } ma_state_t;

endpackage

// File: rtl/mem_addr_align_chk.sv
// Combinational alignment check on the low address bits; fetches must be word aligned.
// Zero latency, no handshake. Also used by the LSU.
module mem_addr_align_chk
  import core_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  input  logic       is_fetch,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    if (is_fetch) begin
      misaligned = (addr_lo != 2'b00);
    end else begin
      case (size)
        SZ_B:    misaligned = 1'b0;
        SZ_H:    misaligned = addr_lo[0];
        SZ_W:    misaligned = (addr_lo != 2'b00);
        default: misaligned = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_addr_unit.sv
// PC holder and memory address mux with req/ready handshake; mem_req rises the cycle after issue.
// Waits on mem_ready for at most WAIT_MAX cycles, then aborts with a timeout pulse.
module mem_addr_unit
  import core_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0010,
  parameter int              WAIT_MAX     = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      pc_sel,
  input  logic            mem_sel,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] alu_out,
  input  logic            mem_ready,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] pc,
  output logic            mem_req,
  output logic            busy,
  output logic            done,
  output logic            misalign,
  output logic            timeout
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  ma_state_t       state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] target;
  logic [1:0]      chk_lo;
  logic            bad_align;

  always_comb begin
    target = pc;
    case (pc_sel)
      PC_REPLAY: target = pc;
      PC_INC:    target = pc + XLEN'(4);
      PC_JUMP:   target = alu_out;
      default:   target = TRAP_VECTOR;
    endcase
  end

  assign chk_lo = mem_sel ? alu_out[1:0] : target[1:0];

  mem_addr_align_chk u_align (
    .addr_lo    (chk_lo),
    .size       (size),
    .is_fetch   (~mem_sel),
    .misaligned (bad_align)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MA_IDLE;
      cnt      <= '0;
      pc       <= RESET_VECTOR;
      addr     <= RESET_VECTOR;
      mem_req  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      misalign <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        MA_IDLE: begin
          if (start) begin
            if (bad_align) begin
              misalign <= 1'b1;
            end else begin
              mem_req <= 1'b1;
              busy    <= 1'b1;
              cnt     <= '0;
              if (mem_sel) begin
                addr  <= alu_out;
                state <= MA_DATA;
              end else begin
                pc    <= target;
                addr  <= target;
                state <= MA_FETCH;
              end
            end
          end
        end
        default: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= MA_IDLE;
          end else if (cnt == CNT_LAST) begin
            // pc deliberately keeps the fetched target; trap handling decides what to replay
            mem_req <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= MA_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_addr_unit.sv
// Directed vector table for mem_addr_unit plus hand sequences for timeout and mid-access reset.
module tb_mem_addr_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  pc_sel;
  logic        mem_sel;
  logic [1:0]  size;
  logic [31:0] alu_out;
  logic        mem_ready;
  logic [31:0] addr, pc;
  logic        mem_req, busy, done, misalign, timeout;

  int checks = 0;
  int errors = 0;

  mem_addr_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h10), .WAIT_MAX(15)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc_sel(pc_sel), .mem_sel(mem_sel),
    .size(size), .alu_out(alu_out), .mem_ready(mem_ready), .addr(addr), .pc(pc),
    .mem_req(mem_req), .busy(busy), .done(done), .misalign(misalign), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [1:0]  pc_sel;
    logic        mem_sel;
    logic [1:0]  size;
    logic [31:0] alu_out;
    logic        mem_ready;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_busy;
    logic        e_done;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [1:0] ps, input logic ms, input logic [1:0] sz,
                     input logic [31:0] alu, input logic rdy, input logic [31:0] ea,
                     input logic [31:0] ep, input logic er, input logic eb, input logic ed,
                     input logic em);
    vec_t v;
    v.start = st; v.pc_sel = ps; v.mem_sel = ms; v.size = sz; v.alu_out = alu;
    v.mem_ready = rdy; v.e_addr = ea; v.e_pc = ep; v.e_req = er; v.e_busy = eb;
    v.e_done = ed; v.e_mis = em;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    int to_seen;
    int done_seen;
    bit ended;

    start = 0; pc_sel = 0; mem_sel = 0; size = 0; alu_out = 0; mem_ready = 0;
    rst = 1;
    #2;
    chk("rst_addr", addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_outs", {27'd0, mem_req, busy, done, misalign, timeout}, 32'h0);
    @(negedge clk);
    rst = 0;

    //  st ps     ms sz    alu            rdy  addr          pc            req busy done mis
    add(1, 2'b00, 0, 2'b00, 32'h0,         1, 32'h0,         32'h0,         1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h0,         32'h0,         0, 0, 1, 0);
    add(1, 2'b01, 0, 2'b00, 32'h0,         0, 32'h4,         32'h4,         1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         0, 32'h4,         32'h4,         1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         0, 32'h4,         32'h4,         1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         0, 32'h4,         32'h4,         1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h4,         32'h4,         0, 0, 1, 0);
    add(1, 2'b10, 0, 2'b00, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 1, 0);
    add(1, 2'b01, 0, 2'b00, 32'h0,         1, 32'h0,         32'h0,         1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h0,         32'h0,         0, 0, 1, 0);
    add(1, 2'b10, 0, 2'b00, 32'h100,       1, 32'h100,       32'h100,       1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h100,       32'h100,       0, 0, 1, 0);
    add(1, 2'b10, 0, 2'b00, 32'h102,       1, 32'h100,       32'h100,       0, 0, 0, 1);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h100,       32'h100,       0, 0, 0, 0);
    add(1, 2'b11, 0, 2'b00, 32'h0,         1, 32'h10,        32'h10,        1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h10,        32'h10,        0, 0, 1, 0);
    add(1, 2'b10, 0, 2'b00, 32'h100,       1, 32'h100,       32'h100,       1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h100,       32'h100,       0, 0, 1, 0);
    add(1, 2'b00, 1, 2'b10, 32'h200,       1, 32'h200,       32'h100,       1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h200,       32'h100,       0, 0, 1, 0);
    add(1, 2'b00, 1, 2'b01, 32'h203,       1, 32'h200,       32'h100,       0, 0, 0, 1);
    add(1, 2'b00, 1, 2'b00, 32'h203,       1, 32'h203,       32'h100,       1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h203,       32'h100,       0, 0, 1, 0);
    add(1, 2'b00, 1, 2'b11, 32'h200,       1, 32'h203,       32'h100,       0, 0, 0, 1);
    add(1, 2'b00, 1, 2'b10, 32'h300,       0, 32'h300,       32'h100,       1, 1, 0, 0);
    add(1, 2'b10, 0, 2'b00, 32'h400,       0, 32'h300,       32'h100,       1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h300,       32'h100,       0, 0, 1, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h300,       32'h100,       0, 0, 0, 0);
    add(1, 2'b01, 0, 2'b00, 32'h0,         1, 32'h104,       32'h104,       1, 1, 0, 0);
    add(1, 2'b01, 0, 2'b00, 32'h0,         1, 32'h104,       32'h104,       0, 0, 1, 0);
    add(1, 2'b01, 0, 2'b00, 32'h0,         1, 32'h108,       32'h108,       1, 1, 0, 0);
    add(0, 2'b00, 0, 2'b00, 32'h0,         1, 32'h108,       32'h108,       0, 0, 1, 0);

    foreach (vecs[i]) begin
      start = vecs[i].start; pc_sel = vecs[i].pc_sel; mem_sel = vecs[i].mem_sel;
      size = vecs[i].size; alu_out = vecs[i].alu_out; mem_ready = vecs[i].mem_ready;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_req_busy_done_mis_to", i),
          {27'd0, mem_req, busy, done, misalign, timeout},
          {27'd0, vecs[i].e_req, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_mis, 1'b0});
    end

    // Timeout: word data access with mem_ready held low
    start = 1; mem_sel = 1; size = SZ_W; alu_out = 32'h200; mem_ready = 0;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    req_cycles = 0; to_seen = 0; done_seen = 0; ended = 0;
    for (int c = 0; c < 40 && !ended; c++) begin
      if (mem_req) req_cycles++;
      if (timeout) to_seen++;
      if (done) done_seen++;
      if (!busy) ended = 1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("to_ended", 32'(ended), 32'd1);
    chk("to_req_cycles", req_cycles, 32'd15);
    chk("to_pulse", to_seen, 32'd1);
    chk("to_no_done", done_seen, 32'd0);
    chk("to_pc", pc, 32'h108);
    @(posedge clk);
    @(negedge clk);
    chk("to_pulse_clear", {31'd0, timeout}, 32'd0);

    // Reset in the middle of a data access
    start = 1; mem_sel = 1; size = SZ_W; alu_out = 32'h300; mem_ready = 0;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_req", {30'd0, mem_req, busy}, 32'd3);
    #2 rst = 1;
    #1;
    chk("mid_rst_addr", addr, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_outs", {27'd0, mem_req, busy, done, misalign, timeout}, 32'h0);
    @(negedge clk);
    rst = 0; mem_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_no_done", {27'd0, mem_req, busy, done, misalign, timeout}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
